// File: rtl/rr_req_frontend_if.sv
// rr_req_frontend_if: bundle of client push, arbiter req/grant and output bus signals
// for the round-robin requester front end.
//   master : client/arbiter side (drives in_valid, in_data, grant)
//   slave  : front end side (drives in_ready, req, out_*, err_*, stale_cnt)
interface rr_req_frontend_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 8
);
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_id;
  logic            err_stale;
  logic            err_multi;
  logic [7:0]      stale_cnt;

  modport master (
    output in_valid, in_data, grant,
    input  in_ready, req, out_valid, out_data, out_id, err_stale, err_multi, stale_cnt
  );

  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, req, out_valid, out_data, out_id, err_stale, err_multi, stale_cnt
  );
endinterface

// File: rtl/rr_req_frontend.sv
// rr_req_frontend: per-channel FIFOs feeding an 8-way round-robin arbiter. Drives req
// from FIFO occupancy, pops the channel named by a one-hot grant and registers its head
// entry onto a shared output bus. Flags stale (empty-channel) and multi-hot grants.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   io_bus : slave modport (in_valid/in_data/in_ready, req/grant, out_*, err_*, stale_cnt)
module rr_req_frontend #(
  parameter int unsigned N     = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  rr_req_frontend_if.slave io_bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem  [N][DEPTH];
  logic [PW-1:0] r_wptr [N];
  logic [PW-1:0] r_rptr [N];
  logic [CW-1:0] r_cnt  [N];

  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [2:0]    r_out_id;
  logic          r_err_stale;
  logic          r_err_multi;
  logic [7:0]    r_stale_cnt;

  logic [N-1:0]  w_push;
  logic [N-1:0]  w_pop;
  logic [N-1:0]  w_nonempty;
  logic [N-1:0]  w_ready;
  logic          w_onehot;
  logic          w_multi;
  logic          w_stale;
  logic [2:0]    w_gnt_id;
  logic [DW-1:0] w_head;

  // Grant is ignored entirely while reset is asserted.
  assign w_onehot = !i_rst && (io_bus.grant != '0) &&
                    ((io_bus.grant & (io_bus.grant - N'(1))) == '0);
  assign w_multi  = !i_rst && (io_bus.grant != '0) && !w_onehot;
  assign w_stale  = w_onehot && ((io_bus.grant & w_nonempty) == '0);

  always_comb begin
    w_gnt_id = '0;
    w_head   = '0;
    for (int i = 0; i < N; i++) begin
      w_nonempty[i] = (r_cnt[i] != '0);
      w_ready[i]    = (r_cnt[i] != CW'(DEPTH));
      w_push[i]     = io_bus.in_valid[i] && w_ready[i];
      w_pop[i]      = io_bus.grant[i] && w_onehot && w_nonempty[i];
      // Drop req in the cycle the last entry is granted so the arbiter never regrants it.
      io_bus.req[i] = (r_cnt[i] > CW'(1)) || ((r_cnt[i] == CW'(1)) && !w_pop[i]);
      if (io_bus.grant[i]) w_gnt_id = 3'(i);
      if (w_pop[i])        w_head   = r_mem[i][r_rptr[i]];
    end
  end

  assign io_bus.in_ready = w_ready;

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < N; i++) begin
      if (!i_rst && w_push[i]) r_mem[i][r_wptr[i]] <= io_bus.in_data[i*DW +: DW];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_err_stale <= 1'b0;
      r_err_multi <= 1'b0;
      r_stale_cnt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
        if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + CW'(1);
        else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - CW'(1);
      end
      r_out_valid <= (w_pop != '0);
      if (w_pop != '0) begin
        r_out_data <= w_head;
        r_out_id   <= w_gnt_id;
      end
      if (w_stale) r_err_stale <= 1'b1;
      if (w_multi) r_err_multi <= 1'b1;
      if (w_stale && (r_stale_cnt != 8'hFF)) r_stale_cnt <= r_stale_cnt + 8'd1;
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_id    = r_out_id;
  assign io_bus.err_stale = r_err_stale;
  assign io_bus.err_multi = r_err_multi;
  assign io_bus.stale_cnt = r_stale_cnt;
endmodule

// File: tb/tb_rr_req_frontend.sv
// Directed bench for rr_req_frontend: reset state, single entry latency, fill/order,
// full-plus-pop, stale grants with saturation, multi-hot grant, reset mid-operation.
module tb_rr_req_frontend;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_req_frontend_if #(.N(8), .DW(8)) bus ();

  rr_req_frontend #(.N(8), .DW(8), .DEPTH(4)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = '0;
    bus.grant    = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.req !== 8'h00) begin errors++; $display("FAIL reset_req: got %h want 00", bus.req); end
    checks++; if (bus.in_ready !== 8'hFF) begin errors++; $display("FAIL reset_in_ready: got %h want ff", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00 || bus.out_id !== 3'd0) begin errors++; $display("FAIL reset_out_bus: got %h/%0d want 00/0", bus.out_data, bus.out_id); end
    checks++; if (bus.err_stale !== 1'b0 || bus.err_multi !== 1'b0 || bus.stale_cnt !== 8'd0) begin errors++; $display("FAIL reset_errs: got %b %b %0d want 0 0 0", bus.err_stale, bus.err_multi, bus.stale_cnt); end
  endtask

  task automatic test_single_entry();
    bus.in_valid = 8'h08;
    bus.in_data[3*8 +: 8] = 8'hA5;
    tick();
    bus.in_valid = '0;
    checks++; if (bus.req !== 8'h08) begin errors++; $display("FAIL single_req: got %h want 08", bus.req); end
    tick();
    bus.grant = 8'h08;
    #1;
    checks++; if (bus.req !== 8'h00) begin errors++; $display("FAIL single_req_drop: got %h want 00", bus.req); end
    tick();
    bus.grant = '0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 3'd3 || bus.out_data !== 8'hA5) begin errors++; $display("FAIL single_out: got v=%b id=%0d d=%h want 1 3 a5", bus.out_valid, bus.out_id, bus.out_data); end
    checks++; if (bus.stale_cnt !== 8'd0) begin errors++; $display("FAIL single_stale_cnt: got %0d want 0", bus.stale_cnt); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_fill_order();
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 8'h01;
      bus.in_data[7:0] = 8'h10 + 8'(k);
      tick();
    end
    bus.in_data[7:0] = 8'h14;
    checks++; if (bus.in_ready[0] !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", bus.in_ready[0]); end
    tick();
    bus.in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      bus.grant = 8'h01;
      #1;
      checks++; if (bus.req[0] !== (k < 3)) begin errors++; $display("FAIL fill_req_g%0d: got %b want %b", k, bus.req[0], (k < 3)); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 + 8'(k)) begin errors++; $display("FAIL fill_out%0d: got v=%b d=%h want 1 %h", k, bus.out_valid, bus.out_data, 8'h10 + 8'(k)); end
    end
    bus.grant = '0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.req[0] !== 1'b0 || bus.in_ready[0] !== 1'b1) begin errors++; $display("FAIL fill_empty: got v=%b req=%b rdy=%b want 0 0 1", bus.out_valid, bus.req[0], bus.in_ready[0]); end
  endtask

  task automatic test_full_plus_pop();
    bit [7:0] exp [4];
    exp[0] = 8'h21; exp[1] = 8'h22; exp[2] = 8'h23; exp[3] = 8'h24;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 8'h01;
      bus.in_data[7:0] = 8'h20 + 8'(k);
      tick();
    end
    bus.in_data[7:0] = 8'h24;
    bus.grant = 8'h01;
    #1;
    checks++; if (bus.in_ready[0] !== 1'b0) begin errors++; $display("FAIL fullpop_refuse: got %b want 0", bus.in_ready[0]); end
    tick();
    bus.grant = '0;
    checks++; if (bus.out_data !== 8'h20 || bus.in_ready[0] !== 1'b1) begin errors++; $display("FAIL fullpop_accept: got d=%h rdy=%b want 20 1", bus.out_data, bus.in_ready[0]); end
    tick();
    bus.in_valid = '0;
    checks++; if (bus.in_ready[0] !== 1'b0) begin errors++; $display("FAIL fullpop_count4: got rdy=%b want 0", bus.in_ready[0]); end
    bus.grant = 8'h01;
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.grant = (k < 3) ? 8'h01 : 8'h00;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[k]) begin errors++; $display("FAIL fullpop_drain%0d: got v=%b d=%h want 1 %h", k, bus.out_valid, bus.out_data, exp[k]); end
      tick();
    end
    checks++; if (bus.req !== 8'h00 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got req=%h v=%b want 00 0", bus.req, bus.out_valid); end
  endtask

  task automatic test_stale();
    bus.grant = 8'h20;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stale_no_out: got %b want 0", bus.out_valid); end
    checks++; if (bus.err_stale !== 1'b1 || bus.stale_cnt !== 8'd1 || bus.err_multi !== 1'b0) begin errors++; $display("FAIL stale_first: got %b %0d m=%b want 1 1 0", bus.err_stale, bus.stale_cnt, bus.err_multi); end
    for (int k = 0; k < 300; k++) tick();
    bus.grant = '0;
    checks++; if (bus.stale_cnt !== 8'd255) begin errors++; $display("FAIL stale_saturate: got %0d want 255", bus.stale_cnt); end
    tick();
    checks++; if (bus.err_stale !== 1'b1 || bus.stale_cnt !== 8'd255) begin errors++; $display("FAIL stale_hold: got %b %0d want 1 255", bus.err_stale, bus.stale_cnt); end
  endtask

  task automatic test_multi_hot();
    do_reset();
    bus.in_valid = 8'h11;
    bus.in_data[0*8 +: 8] = 8'h40;
    bus.in_data[4*8 +: 8] = 8'h44;
    tick();
    bus.in_valid = '0;
    bus.grant = 8'h11;
    #1;
    checks++; if (bus.req !== 8'h11) begin errors++; $display("FAIL multi_req: got %h want 11", bus.req); end
    tick();
    bus.grant = '0;
    checks++; if (bus.out_valid !== 1'b0 || bus.req !== 8'h11) begin errors++; $display("FAIL multi_no_pop: got v=%b req=%h want 0 11", bus.out_valid, bus.req); end
    checks++; if (bus.err_multi !== 1'b1 || bus.err_stale !== 1'b0 || bus.stale_cnt !== 8'd0) begin errors++; $display("FAIL multi_flags: got m=%b s=%b c=%0d want 1 0 0", bus.err_multi, bus.err_stale, bus.stale_cnt); end
    bus.grant = 8'h10;
    tick();
    bus.grant = '0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 3'd4 || bus.out_data !== 8'h44 || bus.req !== 8'h01) begin errors++; $display("FAIL multi_after: got v=%b id=%0d d=%h req=%h want 1 4 44 01", bus.out_valid, bus.out_id, bus.out_data, bus.req); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 8'h44;
      bus.in_data[2*8 +: 8] = 8'h50 + 8'(k);
      bus.in_data[6*8 +: 8] = 8'h60 + 8'(k);
      tick();
    end
    bus.in_valid = '0;
    bus.grant = 8'h04;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.grant = '0;
    checks++; if (bus.req !== 8'h00 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state: got req=%h v=%b want 00 0", bus.req, bus.out_valid); end
    checks++; if (bus.err_stale !== 1'b0 || bus.err_multi !== 1'b0 || bus.in_ready !== 8'hFF) begin errors++; $display("FAIL rstmid_flags: got s=%b m=%b rdy=%h want 0 0 ff", bus.err_stale, bus.err_multi, bus.in_ready); end
    bus.grant = 8'h04;
    tick();
    bus.grant = '0;
    checks++; if (bus.out_valid !== 1'b0 || bus.err_stale !== 1'b1 || bus.stale_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_stale: got v=%b s=%b c=%0d want 0 1 1", bus.out_valid, bus.err_stale, bus.stale_cnt); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.grant    = '0;
    test_reset();
    test_single_entry();
    test_fill_order();
    test_full_plus_pop();
    test_stale();
    test_multi_hot();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
